dram_responder: RTL and testbench

- Pin-level responder for the async-DRAM interface driven by the team's DRAM controller. It consumes ra, dram_wd, rwe_n, rucas_n, rlcas_n, rras0_n and rras1_n, and decodes RAS/CAS sequences into single-word accesses on a synchronous backing-memory port (BRAM/SRAM).
- It returns read data to the controller, counts refresh cycles, and flags protocol violations.
- Used as the DRAM substitute on boards without DRAM and as the bench model for the controller.

---
 rtl/dram_responder.sv | 194 +++++++++++++++++++
 tb/tb_dram_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_responder.sv
// Async-DRAM pin responder: decodes RAS/CAS sequences into single-word backing-memory accesses.
// Latency: pin edge acted on 2 clocks after it reaches the pins; one memory request per RAS cycle.
// Backpressure: mem_req is held with stable address/data until mem_ack; pins are not stalled.
module dram_responder #(
    parameter int RFSH_MAX = 512,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       ra,
    input  logic [15:0]      dram_wd,
    input  logic             rwe_n,
    input  logic             rucas_n,
    input  logic             rlcas_n,
    input  logic             rras0_n,
    input  logic             rras1_n,
    output logic [15:0]      dram_rd,
    output logic             mem_req,
    output logic [20:0]      mem_addr,
    output logic             mem_rnw,
    output logic [1:0]       mem_be,
    output logic [15:0]      mem_wd,
    input  logic             mem_ack,
    input  logic [15:0]      mem_rd,
    output logic [CNT_W-1:0] rfsh_cnt,
    output logic             rfsh_err,
    output logic             proto_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ROW  = 3'd1,
        REQ  = 3'd2,
        HOLD = 3'd3,
        RFSH = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RFSH_LIM = CNT_W'(RFSH_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    state_t state, state_nxt;

    logic [9:0]       s_ra;
    logic [15:0]      s_wd;
    logic             s_rwe_n, s_ucas_n, s_lcas_n, s_ras0_n, s_ras1_n;
    logic             p_ucas_n, p_lcas_n, p_ras0_n, p_ras1_n;

    logic [9:0]       row_q;
    logic             chip_q;
    logic [CNT_W-1:0] wdog_cnt;

    logic ras0_fall, ras1_fall, ras_fall;
    logic cas_fall, cas_low, both_ras_low, both_ras_high, all_high, act_ras_high;

    logic do_row, do_req, do_ack, do_rfsh, do_proto;

    // Sample stage s and previous-value stage p; reset loads the idle bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ra     <= '0;
            s_wd     <= '0;
            s_rwe_n  <= 1'b1;
            s_ucas_n <= 1'b1;
            s_lcas_n <= 1'b1;
            s_ras0_n <= 1'b1;
            s_ras1_n <= 1'b1;
            p_ucas_n <= 1'b1;
            p_lcas_n <= 1'b1;
            p_ras0_n <= 1'b1;
            p_ras1_n <= 1'b1;
        end else begin
            s_ra     <= ra;
            s_wd     <= dram_wd;
            s_rwe_n  <= rwe_n;
            s_ucas_n <= rucas_n;
            s_lcas_n <= rlcas_n;
            s_ras0_n <= rras0_n;
            s_ras1_n <= rras1_n;
            p_ucas_n <= s_ucas_n;
            p_lcas_n <= s_lcas_n;
            p_ras0_n <= s_ras0_n;
            p_ras1_n <= s_ras1_n;
        end
    end

    assign ras0_fall     = p_ras0_n & ~s_ras0_n;
    assign ras1_fall     = p_ras1_n & ~s_ras1_n;
    assign ras_fall      = ras0_fall | ras1_fall;
    assign cas_fall      = (p_ucas_n & ~s_ucas_n) | (p_lcas_n & ~s_lcas_n);
    assign cas_low       = ~s_ucas_n | ~s_lcas_n;
    assign both_ras_low  = ~s_ras0_n & ~s_ras1_n;
    assign both_ras_high = s_ras0_n & s_ras1_n;
    assign all_high      = both_ras_high & s_ucas_n & s_lcas_n;
    assign act_ras_high  = chip_q ? s_ras1_n : s_ras0_n;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!both_ras_low && ras_fall)
                    state_nxt = cas_low ? RFSH : ROW;
            end
            ROW: begin
                if (cas_fall)          state_nxt = REQ;
                else if (act_ras_high) state_nxt = IDLE;
            end
            REQ:  if (mem_ack)       state_nxt = HOLD;
            HOLD: if (all_high)      state_nxt = IDLE;
            RFSH: if (both_ras_high) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        do_row   = 1'b0;
        do_req   = 1'b0;
        do_ack   = 1'b0;
        do_rfsh  = 1'b0;
        do_proto = 1'b0;
        case (state)
            IDLE: begin
                if (both_ras_low)  do_proto = 1'b1;
                else if (ras_fall) begin
                    do_rfsh = cas_low;
                    do_row  = ~cas_low;
                end
            end
            ROW: begin
                if (cas_fall)          do_req  = 1'b1;
                else if (act_ras_high) do_rfsh = 1'b1;
            end
            REQ: begin
                do_ack   = mem_ack;
                do_proto = act_ras_high & ~mem_ack;
            end
            HOLD:    do_proto = cas_fall;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q    <= '0;
            chip_q   <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            mem_rnw  <= 1'b1;
            mem_be   <= '0;
            mem_wd   <= '0;
            dram_rd  <= '0;
        end else begin
            if (do_row) begin
                row_q  <= s_ra;
                chip_q <= ras1_fall;
            end
            if (do_req) begin
                mem_req  <= 1'b1;
                mem_addr <= {s_ra, row_q, chip_q};
                mem_rnw  <= s_rwe_n;
                mem_be   <= {~s_ucas_n, ~s_lcas_n};
                mem_wd   <= s_wd;
            end
            if (do_ack) begin
                mem_req <= 1'b0;
                if (mem_rnw) dram_rd <= mem_rd;
            end
        end
    end

    // A counted refresh clears the watchdog and masks the compare in the same clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            rfsh_cnt  <= '0;
            wdog_cnt  <= '0;
            rfsh_err  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (do_rfsh) begin
                rfsh_cnt <= rfsh_cnt + 1'b1;
                wdog_cnt <= '0;
            end else begin
                if (wdog_cnt != CNT_SAT) wdog_cnt <= wdog_cnt + 1'b1;
                if (wdog_cnt == RFSH_LIM) rfsh_err <= 1'b1;
            end
            if (do_proto) proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder: scripted scenarios plus randomized accesses
// checked against an address/data model built from the pin-to-memory mapping.
module tb_dram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ra;
    logic [15:0] dram_wd;
    logic        rwe_n, rucas_n, rlcas_n, rras0_n, rras1_n;
    logic [15:0] dram_rd;
    logic        mem_req;
    logic [20:0] mem_addr;
    logic        mem_rnw;
    logic [1:0]  mem_be;
    logic [15:0] mem_wd;
    logic        mem_ack;
    logic [15:0] mem_rd;
    logic [15:0] rfsh_cnt;
    logic        rfsh_err;
    logic        proto_err;

    int checks = 0;
    int errors = 0;
    int req_cycles = 0;
    logic [15:0] exp_rd;

    dram_responder #(.RFSH_MAX(512), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ra(ra), .dram_wd(dram_wd), .rwe_n(rwe_n),
        .rucas_n(rucas_n), .rlcas_n(rlcas_n), .rras0_n(rras0_n), .rras1_n(rras1_n),
        .dram_rd(dram_rd), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rnw(mem_rnw),
        .mem_be(mem_be), .mem_wd(mem_wd), .mem_ack(mem_ack), .mem_rd(mem_rd),
        .rfsh_cnt(rfsh_cnt), .rfsh_err(rfsh_err), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_req === 1'b1) req_cycles++;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    // Word address: column in the top ten bits, row in the next ten, chip select in bit 0.
    function automatic logic [20:0] exp_addr(input bit chip, input logic [9:0] row, input logic [9:0] col);
        return 21'(col) * 21'd2048 + 21'(row) * 21'd2 + 21'(chip);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_pins;
        ra = '0; dram_wd = '0; rwe_n = 1'b1;
        rucas_n = 1'b1; rlcas_n = 1'b1; rras0_n = 1'b1; rras1_n = 1'b1;
    endtask

    task automatic do_reset;
        rst = 1'b1; idle_pins(); mem_ack = 1'b0; mem_rd = '0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic start_access(input bit chip, input logic [9:0] row, input logic [9:0] col,
                                input bit rnw, input logic [1:0] be, input logic [15:0] wd,
                                output bit got);
        ra = row;
        if (chip) rras1_n = 1'b0; else rras0_n = 1'b0;
        cyc(3);
        ra = col; rwe_n = rnw; dram_wd = wd;
        rucas_n = ~be[1]; rlcas_n = ~be[0];
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            cyc(1);
            if (mem_req === 1'b1) got = 1'b1;
        end
    endtask

    task automatic ack_mem(input logic [15:0] rd);
        mem_ack = 1'b1; mem_rd = rd;
        cyc(1);
        mem_ack = 1'b0; mem_rd = 16'($urandom);
    endtask

    task automatic end_access;
        idle_pins();
        cyc(4);
    endtask

    task automatic cbr(input bit chip, input bit upper);
        if (upper) rucas_n = 1'b0; else rlcas_n = 1'b0;
        cyc(1);
        if (chip) rras1_n = 1'b0; else rras0_n = 1'b0;
        cyc(3);
        idle_pins();
        cyc(3);
    endtask

    task automatic ras_only(input logic [9:0] row);
        ra = row; rras0_n = 1'b0;
        cyc(3);
        idle_pins();
        cyc(3);
    endtask

    task automatic test_reset;
        rst = 1'b1; idle_pins(); mem_ack = 1'b0; mem_rd = 16'hFFFF;
        cyc(3);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_rnw !== 1'b1) begin errors++; $display("FAIL reset_mem_rnw: got %b expected 1", mem_rnw); end
        checks++; if (mem_addr !== 21'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if ({mem_be, mem_wd} !== 18'h0) begin errors++; $display("FAIL reset_be_wd: got %h expected 0", {mem_be, mem_wd}); end
        checks++; if (dram_rd !== 16'h0) begin errors++; $display("FAIL reset_dram_rd: got %h expected 0", dram_rd); end
        checks++; if (rfsh_cnt !== 16'h0) begin errors++; $display("FAIL reset_rfsh_cnt: got %0d expected 0", rfsh_cnt); end
        checks++; if ({rfsh_err, proto_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {rfsh_err, proto_err}); end
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_read;
        bit got;
        do_reset();
        start_access(1'b1, 10'h155, 10'h2AA, 1'b1, 2'b11, 16'h0, got);
        checks++; if (!got) begin errors++; $display("FAIL read_req: got no mem_req expected mem_req within 8 clocks"); end
        checks++; if (mem_addr !== 21'h1552AB) begin errors++; $display("FAIL read_addr: got %h expected 1552ab", mem_addr); end
        checks++; if ({mem_rnw, mem_be} !== 3'b111) begin errors++; $display("FAIL read_rnw_be: got %b expected 111", {mem_rnw, mem_be}); end
        cyc(2);
        ack_mem(16'hBEEF);
        exp_rd = 16'hBEEF;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL read_req_drop: got %b expected 0", mem_req); end
        checks++; if (dram_rd !== exp_rd) begin errors++; $display("FAIL read_data: got %h expected %h", dram_rd, exp_rd); end
        end_access();
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL read_proto: got %b expected 0", proto_err); end
    endtask

    task automatic test_write;
        bit got;
        start_access(1'b0, 10'h003, 10'h001, 1'b0, 2'b01, 16'h12A5, got);
        checks++; if (!got) begin errors++; $display("FAIL write_req: got no mem_req expected mem_req within 8 clocks"); end
        checks++; if (mem_addr !== 21'h000806) begin errors++; $display("FAIL write_addr: got %h expected 000806", mem_addr); end
        checks++; if ({mem_rnw, mem_be} !== 3'b001) begin errors++; $display("FAIL write_rnw_be: got %b expected 001", {mem_rnw, mem_be}); end
        checks++; if (mem_wd !== 16'h12A5) begin errors++; $display("FAIL write_wd: got %h expected 12a5", mem_wd); end
        ack_mem(16'h5555);
        checks++; if (dram_rd !== exp_rd) begin errors++; $display("FAIL write_keeps_rd: got %h expected %h", dram_rd, exp_rd); end
        end_access();
    endtask

    task automatic test_refresh;
        int r0;
        do_reset();
        r0 = req_cycles;
        for (int i = 0; i < 10; i++) cbr(i[0], i[1]);
        ras_only(10'($urandom));
        checks++; if (rfsh_cnt !== 16'd11) begin errors++; $display("FAIL rfsh_count: got %0d expected 11", rfsh_cnt); end
        checks++; if (req_cycles !== r0) begin errors++; $display("FAIL rfsh_no_req: got %0d req clocks expected %0d", req_cycles, r0); end
        checks++; if (rfsh_err !== 1'b0) begin errors++; $display("FAIL rfsh_err_early: got %b expected 0", rfsh_err); end
        cyc(500);
        checks++; if (rfsh_err !== 1'b0) begin errors++; $display("FAIL rfsh_err_before_limit: got %b expected 0", rfsh_err); end
        cyc(20);
        checks++; if (rfsh_err !== 1'b1) begin errors++; $display("FAIL rfsh_err_set: got %b expected 1", rfsh_err); end
        cbr(1'b0, 1'b0);
        cyc(10);
        checks++; if (rfsh_err !== 1'b1) begin errors++; $display("FAIL rfsh_err_sticky: got %b expected 1", rfsh_err); end
    endtask

    task automatic test_late_ack;
        bit got, held;
        logic [9:0] row, col;
        logic [15:0] d;
        do_reset();
        row = 10'($urandom); col = 10'($urandom); d = 16'($urandom);
        start_access(1'b0, row, col, 1'b1, 2'b11, 16'h0, got);
        checks++; if (!got || mem_addr !== exp_addr(1'b0, row, col)) begin errors++; $display("FAIL late_req_addr: got req=%b addr=%h expected req=1 addr=%h", got, mem_addr, exp_addr(1'b0, row, col)); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL late_proto_early: got %b expected 0", proto_err); end
        rras0_n = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (mem_req !== 1'b1 || mem_addr !== exp_addr(1'b0, row, col) || mem_be !== 2'b11) held = 1'b0;
        end
        checks++; if (!held) begin errors++; $display("FAIL late_req_stable: got unstable request expected stable for 6 clocks"); end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL late_proto: got %b expected 1", proto_err); end
        ack_mem(d);
        checks++; if (mem_req !== 1'b0 || dram_rd !== d) begin errors++; $display("FAIL late_data: got req=%b rd=%h expected req=0 rd=%h", mem_req, dram_rd, d); end
        end_access();
    endtask

    task automatic test_both_ras;
        bit got;
        int r0;
        logic [9:0] row, col;
        logic [15:0] d;
        do_reset();
        r0 = req_cycles;
        rras0_n = 1'b0; rras1_n = 1'b0;
        cyc(4);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL both_ras_proto: got %b expected 1", proto_err); end
        checks++; if (req_cycles !== r0) begin errors++; $display("FAIL both_ras_no_req: got %0d req clocks expected %0d", req_cycles, r0); end
        idle_pins();
        cyc(3);
        row = 10'($urandom); col = 10'($urandom); d = 16'($urandom);
        start_access(1'b1, row, col, 1'b1, 2'b10, 16'h0, got);
        checks++; if (!got || mem_addr !== exp_addr(1'b1, row, col) || mem_be !== 2'b10) begin errors++; $display("FAIL both_ras_next: got req=%b addr=%h be=%b expected req=1 addr=%h be=10", got, mem_addr, mem_be, exp_addr(1'b1, row, col)); end
        ack_mem(d);
        checks++; if (dram_rd !== d) begin errors++; $display("FAIL both_ras_next_data: got %h expected %h", dram_rd, d); end
        end_access();
    endtask

    task automatic test_reset_mid_req;
        bit got;
        logic [9:0] row, col;
        logic [15:0] d;
        do_reset();
        cbr(1'b1, 1'b1);
        rras0_n = 1'b0; rras1_n = 1'b0;
        cyc(3);
        idle_pins();
        cyc(3);
        start_access(1'b1, 10'h2F0, 10'h10F, 1'b1, 2'b11, 16'h0, got);
        ack_mem(16'hA5A5);
        end_access();
        start_access(1'b0, 10'h011, 10'h022, 1'b1, 2'b11, 16'h0, got);
        checks++; if (!got) begin errors++; $display("FAIL rstreq_req: got no mem_req expected mem_req within 8 clocks"); end
        rst = 1'b1; idle_pins();
        cyc(1);
        rst = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstreq_req_drop: got %b expected 0", mem_req); end
        checks++; if (rfsh_cnt !== 16'h0 || dram_rd !== 16'h0) begin errors++; $display("FAIL rstreq_counts: got cnt=%0d rd=%h expected cnt=0 rd=0", rfsh_cnt, dram_rd); end
        checks++; if ({rfsh_err, proto_err} !== 2'b00) begin errors++; $display("FAIL rstreq_flags: got %b expected 00", {rfsh_err, proto_err}); end
        cyc(2);
        row = 10'($urandom); col = 10'($urandom); d = 16'($urandom);
        start_access(1'b0, row, col, 1'b0, 2'b10, d, got);
        checks++; if (!got || mem_addr !== exp_addr(1'b0, row, col) || mem_wd !== d || mem_rnw !== 1'b0) begin errors++; $display("FAIL rstreq_clean: got req=%b addr=%h wd=%h rnw=%b expected req=1 addr=%h wd=%h rnw=0", got, mem_addr, mem_wd, mem_rnw, exp_addr(1'b0, row, col), d); end
        ack_mem(16'hFFFF);
        end_access();
        checks++; if (dram_rd !== 16'h0 || proto_err !== 1'b0) begin errors++; $display("FAIL rstreq_after: got rd=%h proto=%b expected rd=0 proto=0", dram_rd, proto_err); end
    endtask

    task automatic test_random;
        bit got, chip, rnw;
        logic [9:0] row, col;
        logic [1:0] be;
        logic [15:0] wd, rd;
        do_reset();
        exp_rd = 16'h0;
        for (int n = 0; n < 12; n++) begin
            chip = 1'($urandom); rnw = 1'($urandom);
            row = 10'($urandom); col = 10'($urandom);
            be = 2'($urandom_range(1, 3));
            wd = 16'($urandom); rd = 16'($urandom);
            start_access(chip, row, col, rnw, be, wd, got);
            checks++; if (!got || mem_addr !== exp_addr(chip, row, col)) begin errors++; $display("FAIL rand_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h", n, got, mem_addr, exp_addr(chip, row, col)); end
            checks++; if ({mem_rnw, mem_be} !== {rnw, be}) begin errors++; $display("FAIL rand_rnw_be[%0d]: got %b expected %b", n, {mem_rnw, mem_be}, {rnw, be}); end
            if (!rnw) begin
                checks++; if (mem_wd !== wd) begin errors++; $display("FAIL rand_wd[%0d]: got %h expected %h", n, mem_wd, wd); end
            end
            cyc($urandom_range(0, 3));
            ack_mem(rd);
            if (rnw) exp_rd = rd;
            checks++; if (dram_rd !== exp_rd) begin errors++; $display("FAIL rand_rd[%0d]: got %h expected %h", n, dram_rd, exp_rd); end
            end_access();
        end
        checks++; if (proto_err !== 1'b0 || rfsh_cnt !== 16'h0) begin errors++; $display("FAIL rand_side_effects: got proto=%b cnt=%0d expected proto=0 cnt=0", proto_err, rfsh_cnt); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_refresh();
        test_late_ack();
        test_both_ras();
        test_reset_mid_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
